// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encoding and default width.
package serial_adder_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// One-bit full adder fa_v1, built from two ha_v1_1 half adders; the serial controller's bit slice.
module ha_v1_1 (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

module fa_v1 (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  logic s0;
  logic c0;
  logic c1;

  ha_v1_1 u_ha0 (
    .a     (a),
    .b     (b),
    .sum   (s0),
    .carry (c0)
  );

  ha_v1_1 u_ha1 (
    .a     (s0),
    .b     (c_in),
    .sum   (sum),
    .carry (c1)
  );

  assign c_out = c0 | c1;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: feeds fa_v1 one bit pair per clock, LSB first, with start/busy/done handshake.
//
// state  | meaning
// S_IDLE | waiting for start; operands captured on the accepted edge
// S_RUN  | one operand bit pair per clock through fa_v1
// S_DONE | result just published; one cycle, then back to idle
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shift_a;
  logic [WIDTH-1:0] shift_b;
  logic [WIDTH-1:0] shift_s;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_sum;
  logic             fa_c_out;

  fa_v1 u_fa (
    .a     (shift_a[0]),
    .b     (shift_b[0]),
    .c_in  (carry),
    .sum   (fa_sum),
    .c_out (fa_c_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      c_out   <= 1'b0;
      shift_a <= '0;
      shift_b <= '0;
      shift_s <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            shift_a <= a;
            shift_b <= b;
            carry   <= c_in;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          carry   <= fa_c_out;
          shift_a <= {1'b0, shift_a[WIDTH-1:1]};
          shift_b <= {1'b0, shift_b[WIDTH-1:1]};
          shift_s <= {fa_sum, shift_s[WIDTH-1:1]};
          // Last bit goes straight into the published result, so sum lands on the same edge.
          if (cnt == CNT_LAST) begin
            sum   <= {fa_sum, shift_s[WIDTH-1:1]};
            c_out <= fa_c_out;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: an 8-bit instance for scenarios, a 4-bit instance swept exhaustively.
module tb_serial_adder_ctrl;

  logic       clk;
  logic       rst_n;

  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       c_in8;
  logic       busy8;
  logic       done8;
  logic [7:0] sum8;
  logic       c_out8;

  logic       start4;
  logic [3:0] a4;
  logic [3:0] b4;
  logic       c_in4;
  logic       busy4;
  logic       done4;
  logic [3:0] sum4;
  logic       c_out4;

  int total;
  int bad;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .c_in  (c_in8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .c_out (c_out8)
  );

  serial_adder_ctrl #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .c_in  (c_in4),
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .c_out (c_out4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    total++;
    if ({busy8, done8, sum8, c_out8} !== 11'h000) begin
      bad++;
      $display("FAIL reset_hold: got busy=%b done=%b sum=%h c_out=%b want all zero", busy8, done8, sum8, c_out8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++;
    if ({busy8, done8, sum8, c_out8} !== 11'h000) begin
      bad++;
      $display("FAIL reset_release: got busy=%b done=%b sum=%h c_out=%b want all zero", busy8, done8, sum8, c_out8);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({busy8, done8, sum8, c_out8} !== 11'h000 || {busy4, done4} !== 2'b00) begin
        bad++;
        $display("FAIL idle_no_start[%0d]: got busy=%b done=%b sum=%h c_out=%b want idle zeros", i, busy8, done8, sum8, c_out8);
      end
    end
  endtask

  // One 8-bit addition: checks busy, held result during RUN, latency, result, pulse width and busy fall.
  task automatic run_add8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                          input logic [7:0] exp_sum, input logic exp_cout, input string name);
    logic [7:0] prev_sum;
    logic       prev_cout;
    int         lat;
    prev_sum  = sum8;
    prev_cout = c_out8;
    start8 = 1'b1; a8 = ta; b8 = tb; c_in8 = tc;
    tick();
    start8 = 1'b0; a8 = ~ta; b8 = 8'h5A; c_in8 = ~tc;
    total++;
    if (busy8 !== 1'b1 || done8 !== 1'b0) begin
      bad++;
      $display("FAIL %s_busy_rise: got busy=%b done=%b want busy=1 done=0", name, busy8, done8);
    end
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (done8 === 1'b1) begin
        lat = k;
        break;
      end
      if (k == 3) begin
        total++;
        if (sum8 !== prev_sum || c_out8 !== prev_cout) begin
          bad++;
          $display("FAIL %s_hold_run: got sum=%h c_out=%b want %h %b", name, sum8, c_out8, prev_sum, prev_cout);
        end
      end
    end
    total++;
    if (lat != 8) begin
      bad++;
      $display("FAIL %s_latency: got done after %0d edges want 8", name, lat);
    end
    total++;
    if (sum8 !== exp_sum || c_out8 !== exp_cout || busy8 !== 1'b1) begin
      bad++;
      $display("FAIL %s_result: got sum=%h c_out=%b busy=%b want sum=%h c_out=%b busy=1",
               name, sum8, c_out8, busy8, exp_sum, exp_cout);
    end
    tick();
    total++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== exp_sum || c_out8 !== exp_cout) begin
      bad++;
      $display("FAIL %s_after: got busy=%b done=%b sum=%h c_out=%b want busy=0 done=0 sum=%h c_out=%b",
               name, busy8, done8, sum8, c_out8, exp_sum, exp_cout);
    end
  endtask

  task automatic test_basic();
    run_add8(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, "add_3c_0f");
  endtask

  task automatic test_carry_cases();
    run_add8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "add_ff_01");
    run_add8(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, "add_a5_5a_c1");
    run_add8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "add_zero");
  endtask

  // Start held high: second operation must wait for IDLE and pick up the operands present then.
  task automatic test_back_to_back();
    int done_edges[$];
    int prev_done;
    logic [7:0] s1, s2;
    logic c1, c2;
    prev_done = 0;
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; c_in8 = 1'b0;
    tick();
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (k == 3) begin
        a8 = 8'hFF; b8 = 8'hFF;
      end
      if (done8 === 1'b1) begin
        if (prev_done == 1) begin
          total++;
          bad++;
          $display("FAIL b2b_pulse_width: done high on consecutive edges at %0d", k);
        end
        done_edges.push_back(k);
        if (done_edges.size() == 1) begin
          s1 = sum8; c1 = c_out8;
        end else if (done_edges.size() == 2) begin
          s2 = sum8; c2 = c_out8;
          start8 = 1'b0;
        end
      end
      prev_done = (done8 === 1'b1) ? 1 : 0;
    end
    total++;
    if (done_edges.size() != 2) begin
      bad++;
      $display("FAIL b2b_done_count: got %0d done pulses want 2", done_edges.size());
    end else begin
      total++;
      if (done_edges[0] != 8 || s1 !== 8'h46 || c1 !== 1'b0) begin
        bad++;
        $display("FAIL b2b_first: got edge=%0d sum=%h c_out=%b want edge=8 sum=46 c_out=0", done_edges[0], s1, c1);
      end
      total++;
      if (done_edges[1] != 18 || s2 !== 8'hFE || c2 !== 1'b1) begin
        bad++;
        $display("FAIL b2b_second: got edge=%0d sum=%h c_out=%b want edge=18 sum=fe c_out=1", done_edges[1], s2, c2);
      end
    end
    start8 = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_run();
    int saw_done;
    saw_done = 0;
    start8 = 1'b1; a8 = 8'h80; b8 = 8'h80; c_in8 = 1'b0;
    tick();
    start8 = 1'b0;
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy8, done8, sum8, c_out8} !== 11'h000) begin
      bad++;
      $display("FAIL midrst_async: got busy=%b done=%b sum=%h c_out=%b want all zero", busy8, done8, sum8, c_out8);
    end
    repeat (2) begin
      tick();
      if (done8 === 1'b1) saw_done = 1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done8 === 1'b1) saw_done = 1;
    end
    total++;
    if (saw_done != 0 || busy8 !== 1'b0 || sum8 !== 8'h00) begin
      bad++;
      $display("FAIL midrst_no_result: got saw_done=%0d busy=%b sum=%h want 0 0 00", saw_done, busy8, sum8);
    end
    run_add8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, "add_after_rst");
  endtask

  task automatic test_exhaustive4();
    int lat;
    logic [4:0] exp;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          exp = 5'(ia) + 5'(ib) + 5'(ic);
          start4 = 1'b1; a4 = 4'(ia); b4 = 4'(ib); c_in4 = 1'(ic);
          tick();
          start4 = 1'b0; a4 = 4'(~ia); b4 = 4'(ia); c_in4 = 1'(~ic);
          lat = 0;
          for (int k = 1; k <= 10; k++) begin
            tick();
            if (done4 === 1'b1) begin
              lat = k;
              break;
            end
          end
          total++;
          if (lat != 4 || {c_out4, sum4} !== exp) begin
            bad++;
            $display("FAIL exh4 a=%h b=%h c=%0d: got lat=%0d {c_out,sum}=%h want lat=4 %h",
                     ia, ib, ic, lat, {c_out4, sum4}, exp);
          end
          tick();
          total++;
          if (done4 !== 1'b0 || busy4 !== 1'b0) begin
            bad++;
            $display("FAIL exh4_pulse a=%h b=%h c=%0d: got done=%b busy=%b want 0 0", ia, ib, ic, done4, busy4);
          end
        end
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; c_in8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; c_in4 = 1'b0;
    #2;
    test_reset();
    test_basic();
    test_carry_cases();
    test_back_to_back();
    test_reset_mid_run();
    test_exhaustive4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
